// File: rtl/rambus_load_sched.sv
// rambus_load_sched: round-robin scheduler sharing one AXI-read-to-RAM engine between
// the input-buffer and weight-buffer loaders, with gap enforcement and a watchdog.
module rambus_load_sched #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_GAP_CYCLES       = 2,
  parameter int C_TIMEOUT_WIDTH    = 16
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic [1:0]                    I_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr0,
  input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len0,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr1,
  input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len1,
  output logic [1:0]                    O_ack,
  output logic [1:0]                    O_done,
  output logic [1:0]                    O_err,
  output logic                          O_ap_start,
  input  logic                          I_ap_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] O_base_addr,
  output logic [C_RAM_ADDR_WIDTH-1:0]   O_len,
  output logic                          O_ram_sel,
  output logic                          O_busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_RUN = 2'd2, S_GAP = 2'd3;
  localparam int GW = $clog2(C_GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(C_GAP_CYCLES - 1);
  logic [1:0] state;
  logic last;
  logic [C_TIMEOUT_WIDTH-1:0] wd, wd_nxt;
  logic [GW-1:0] gap;
  logic w;
  logic [1:0] sel_mask;
  always_comb begin
    w = &I_req ? ~last : I_req[1];
    wd_nxt = wd + C_TIMEOUT_WIDTH'(1);
    sel_mask = {O_ram_sel, ~O_ram_sel};
  end
  assign O_busy = state != S_IDLE;
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= S_IDLE;
      last <= 1'b1;
      wd <= '0;
      gap <= '0;
      O_ack <= '0;
      O_done <= '0;
      O_err <= '0;
      O_ap_start <= 1'b0;
      O_base_addr <= '0;
      O_len <= '0;
      O_ram_sel <= 1'b0;
    end else begin
      O_ack <= '0;
      O_done <= '0;
      O_err <= '0;
      case (state)
        S_IDLE: if (|I_req) begin
          O_base_addr <= w ? I_base_addr1 : I_base_addr0;
          O_len <= w ? I_len1 : I_len0;
          O_ram_sel <= w;
          O_ack <= w ? 2'b10 : 2'b01;
          last <= w;
          state <= S_GRANT;
        end
        // a zero-length job must never start the engine: it would underflow len-1
        S_GRANT: if (O_len == '0) begin
          O_done <= sel_mask;
          gap <= '0;
          state <= S_GAP;
        end else begin
          O_ap_start <= 1'b1;
          wd <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          wd <= wd_nxt;
          if (I_ap_done || wd_nxt == '1) begin
            O_ap_start <= 1'b0;
            O_done <= sel_mask;
            O_err <= I_ap_done ? 2'b00 : sel_mask;
            gap <= '0;
            state <= S_GAP;
          end
        end
        default: if (gap == GAP_LAST) state <= S_IDLE; else gap <= gap + GW'(1);
      endcase
    end
  end
endmodule
